// File: rtl/rv_ctrl_sequencer_pkg.sv
// Shared types and constants for the RV32I multi-cycle control sequencer.
package rv_ctrl_sequencer_pkg;

    // Encoding is visible on state_o, so the values are pinned explicitly.
    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StFetchWait = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMem       = 3'd4,
        StMemWait   = 3'd5,
        StHalt      = 3'd6
    } state_e;

    // Write-back source select
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_PC4  = 2'd1;
    localparam logic [1:0] WB_SEL_LOAD = 2'd2;

    // Resolved instruction class after priority arbitration
    typedef enum logic [2:0] {
        ClsAlu,
        ClsSystem,
        ClsLoad,
        ClsStore,
        ClsJump,
        ClsBranch
    } instr_cls_e;

    // Decoder classes should be one-hot; if not, system > load > store > jump > branch.
    function automatic instr_cls_e classify(
        input logic is_system,
        input logic is_load,
        input logic is_store,
        input logic is_jal,
        input logic is_jalr,
        input logic is_branch
    );
        instr_cls_e cls;
        if (is_system) begin
            cls = ClsSystem;
        end else if (is_load) begin
            cls = ClsLoad;
        end else if (is_store) begin
            cls = ClsStore;
        end else if (is_jal || is_jalr) begin
            cls = ClsJump;
        end else if (is_branch) begin
            cls = ClsBranch;
        end else begin
            cls = ClsAlu;
        end
        return cls;
    endfunction

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv_ctrl_sequencer.sv
// Multi-cycle control FSM for the RV32I core: owns the PC, sequences fetch,
// decode, execute, load/store and write-back over one shared memory port.
module rv_ctrl_sequencer
    import rv_ctrl_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_system,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        is_branch,
    input  logic        take_branch,
    input  logic [31:0] jump_target,
    input  logic [31:0] ls_addr,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic        instr_we,
    output logic        regs_re,
    output logic        wb_en,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic [2:0]  state_o
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    // Data-side request captured in MEM so it stays stable through MEM_WAIT.
    logic [31:0] daddr_q, daddr_d;
    logic        dwe_q, dwe_d;
    logic        dload_q, dload_d;

    instr_cls_e  cls;
    logic [31:0] pc_seq;
    logic [31:0] pc_jump;

    assign cls     = classify(is_system, is_load, is_store, is_jal, is_jalr, is_branch);
    assign pc_seq  = pc_q + 32'(PC_STEP);
    assign pc_jump = align_word(jump_target);

    // Next-state, PC and captured data request; synchronous reset overrides all.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        daddr_d = daddr_q;
        dwe_d   = dwe_q;
        dload_d = dload_q;

        unique case (state_q)
            StFetch: begin
                // Ready in the cycle the request rises is not a completion.
                state_d = StFetchWait;
            end
            StFetchWait: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StExecute;
            end
            StExecute: begin
                case (cls)
                    ClsSystem: begin
                        state_d = StHalt;
                    end
                    ClsLoad, ClsStore: begin
                        state_d = StMem;
                    end
                    ClsJump: begin
                        pc_d    = pc_jump;
                        state_d = StFetch;
                    end
                    ClsBranch: begin
                        pc_d    = take_branch ? pc_jump : pc_seq;
                        state_d = StFetch;
                    end
                    default: begin
                        pc_d    = pc_seq;
                        state_d = StFetch;
                    end
                endcase
            end
            StMem: begin
                daddr_d = ls_addr;
                dwe_d   = (cls == ClsStore);
                dload_d = (cls == ClsLoad);
                state_d = StMemWait;
            end
            StMemWait: begin
                if (mem_ready) begin
                    pc_d    = pc_seq;
                    state_d = StFetch;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        if (!resetn) begin
            state_d = StFetch;
            pc_d    = align_word(RESET_PC);
            daddr_d = '0;
            dwe_d   = 1'b0;
            dload_d = 1'b0;
        end
    end

    // State, PC and data-request registers.
    always_ff @(posedge CLK) begin
        state_q <= state_d;
        pc_q    <= pc_d;
        daddr_q <= daddr_d;
        dwe_q   <= dwe_d;
        dload_q <= dload_d;
    end

    // Strobe and memory-port decode from the current state.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_q;
        instr_we = 1'b0;
        regs_re  = 1'b0;
        wb_en    = 1'b0;
        wb_sel   = WB_SEL_ALU;
        halted   = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
            end
            StFetchWait: begin
                mem_req  = 1'b1;
                instr_we = mem_ready;
            end
            StDecode: begin
                regs_re = 1'b1;
            end
            StExecute: begin
                case (cls)
                    ClsJump: begin
                        wb_en  = 1'b1;
                        wb_sel = WB_SEL_PC4;
                    end
                    ClsAlu: begin
                        wb_en  = 1'b1;
                        wb_sel = WB_SEL_ALU;
                    end
                    default: begin
                        wb_en = 1'b0;
                    end
                endcase
            end
            StMem: begin
                mem_req  = 1'b1;
                mem_addr = ls_addr;
                mem_we   = (cls == ClsStore);
            end
            StMemWait: begin
                mem_req  = 1'b1;
                mem_addr = daddr_q;
                mem_we   = dwe_q;
                if (mem_ready && dload_q) begin
                    wb_en  = 1'b1;
                    wb_sel = WB_SEL_LOAD;
                end
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase

        // Outputs stay quiet while reset is held, even though the state is FETCH.
        if (!resetn) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            instr_we = 1'b0;
            regs_re  = 1'b0;
            wb_en    = 1'b0;
            wb_sel   = WB_SEL_ALU;
            halted   = 1'b0;
        end
    end

    assign pc      = pc_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_rv_ctrl_sequencer.sv
// Self-checking bench for rv_ctrl_sequencer: directed table, corner sequences,
// and a randomized instruction stream checked against a per-instruction model.
module tb_rv_ctrl_sequencer;

    localparam logic [5:0] C_ALU  = 6'b000000;
    localparam logic [5:0] C_SYS  = 6'b100000;
    localparam logic [5:0] C_LD   = 6'b010000;
    localparam logic [5:0] C_ST   = 6'b001000;
    localparam logic [5:0] C_JAL  = 6'b000100;
    localparam logic [5:0] C_JALR = 6'b000010;
    localparam logic [5:0] C_BR   = 6'b000001;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic        is_load = 1'b0, is_store = 1'b0, is_system = 1'b0;
    logic        is_jal = 1'b0, is_jalr = 1'b0, is_branch = 1'b0;
    logic        take_branch = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] ls_addr = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] pc;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic        instr_we, regs_re, wb_en;
    logic [1:0]  wb_sel;
    logic        halted;
    logic [2:0]  state_o;

    always #5 CLK = ~CLK;

    rv_ctrl_sequencer dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_system  (is_system),
        .is_jal     (is_jal),
        .is_jalr    (is_jalr),
        .is_branch  (is_branch),
        .take_branch(take_branch),
        .jump_target(jump_target),
        .ls_addr    (ls_addr),
        .mem_ready  (mem_ready),
        .pc         (pc),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .instr_we   (instr_we),
        .regs_re    (regs_re),
        .wb_en      (wb_en),
        .wb_sel     (wb_sel),
        .halted     (halted),
        .state_o    (state_o)
    );

    // cls = {system, load, store, jal, jalr, branch}
    typedef struct {
        logic [5:0]  cls;
        logic        tk;
        logic [31:0] target;
        logic [31:0] lsa;
        int          fd;
        int          md;
        logic [31:0] exp_pc;
        logic        exp_wb;
        logic [1:0]  exp_sel;
        logic        exp_mem;
        logic        exp_we;
        logic        exp_halt;
        int          exp_cyc;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] model_pc = '0;
    vec_t        tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] cls, input logic tk, input logic [31:0] target,
                                input logic [31:0] lsa, input int fd, input int md,
                                input logic [31:0] exp_pc, input logic exp_wb,
                                input logic [1:0] exp_sel, input logic exp_mem,
                                input logic exp_we, input logic exp_halt, input int exp_cyc);
        vec_t v;
        v.cls = cls; v.tk = tk; v.target = target; v.lsa = lsa; v.fd = fd; v.md = md;
        v.exp_pc = exp_pc; v.exp_wb = exp_wb; v.exp_sel = exp_sel; v.exp_mem = exp_mem;
        v.exp_we = exp_we; v.exp_halt = exp_halt; v.exp_cyc = exp_cyc;
        return v;
    endfunction

    // Instruction-level reference: outcome of one instruction from the class rules.
    function automatic vec_t model(input vec_t v, input logic [31:0] cur);
        vec_t        e;
        logic [31:0] seq;
        logic [31:0] tgt;
        e   = v;
        seq = cur + 32'd4;
        tgt = (v.target / 4) * 4;
        e.exp_pc = seq; e.exp_wb = 1'b0; e.exp_sel = 2'd0;
        e.exp_mem = 1'b0; e.exp_we = 1'b0; e.exp_halt = 1'b0;
        if (v.cls[5]) begin
            e.exp_halt = 1'b1; e.exp_pc = cur;
        end else if (v.cls[4]) begin
            e.exp_mem = 1'b1; e.exp_wb = 1'b1; e.exp_sel = 2'd2;
        end else if (v.cls[3]) begin
            e.exp_mem = 1'b1; e.exp_we = 1'b1;
        end else if (v.cls[2] || v.cls[1]) begin
            e.exp_pc = tgt; e.exp_wb = 1'b1; e.exp_sel = 2'd1;
        end else if (v.cls[0]) begin
            e.exp_pc = v.tk ? tgt : seq;
        end else begin
            e.exp_wb = 1'b1;
        end
        // fetch (1 + wait >= 1) + decode + execute [+ mem (1 + wait >= 1)] [+ halt sample]
        e.exp_cyc = 1 + ((v.fd < 1) ? 1 : v.fd) + 2
                  + (e.exp_mem ? 1 + ((v.md < 1) ? 1 : v.md) : 0)
                  + (e.exp_halt ? 1 : 0);
        return e;
    endfunction

    // Entry point: just after a posedge with the DUT in FETCH. Memory answers once
    // the request has been up for at least `delay` cycles since it rose or last completed.
    task automatic run_vec(input vec_t v, input string tag);
        int   cyc = 0;
        int   hist = 0;
        int   d;
        int   n_iwe = 0, n_re = 0, n_wb = 0;
        logic seen_re = 1'b0, data_req = 1'b0, fetch_bad = 1'b0, data_bad = 1'b0;
        logic overlap = 1'b0, done = 1'b0;
        logic [1:0] sel = 2'd0;
        {is_system, is_load, is_store, is_jal, is_jalr, is_branch} = v.cls;
        take_branch = v.tk;
        jump_target = v.target;
        ls_addr     = v.lsa;
        while (!done && cyc < 80) begin
            @(negedge CLK);
            d = seen_re ? v.md : v.fd;
            mem_ready = mem_req ? (hist >= d) : 1'($urandom % 2);
            #1;
            if (mem_req) begin
                if (!seen_re) begin
                    if (mem_addr !== model_pc || mem_we !== 1'b0) fetch_bad = 1'b1;
                end else begin
                    data_req = 1'b1;
                    if (mem_addr !== v.lsa || mem_we !== v.exp_we) data_bad = 1'b1;
                end
            end
            if ((int'(instr_we) + int'(regs_re) + int'(wb_en)) > 1) overlap = 1'b1;
            if (instr_we) n_iwe++;
            if (regs_re) begin n_re++; seen_re = 1'b1; end
            if (wb_en) begin n_wb++; sel = wb_sel; end
            if (mem_req) hist = mem_ready ? 0 : hist + 1;
            else hist = 0;
            cyc++;
            if (halted) begin
                done = 1'b1;
            end else begin
                @(posedge CLK);
                #1;
                if (state_o == 3'd0) done = 1'b1;
            end
        end
        chk({tag, " completed"}, 32'(done), 32'd1);
        chk({tag, " cycles"}, cyc, v.exp_cyc);
        chk({tag, " pc"}, pc, v.exp_pc);
        chk({tag, " instr_we count"}, n_iwe, 1);
        chk({tag, " regs_re count"}, n_re, 1);
        chk({tag, " wb_en count"}, n_wb, 32'(v.exp_wb));
        if (v.exp_wb) chk({tag, " wb_sel"}, 32'(sel), 32'(v.exp_sel));
        chk({tag, " data req seen"}, 32'(data_req), 32'(v.exp_mem));
        chk({tag, " fetch addr/we"}, 32'(fetch_bad), 32'd0);
        chk({tag, " data addr/we"}, 32'(data_bad), 32'd0);
        chk({tag, " strobe overlap"}, 32'(overlap), 32'd0);
        chk({tag, " halted"}, 32'(halted), 32'(v.exp_halt));
        model_pc = v.exp_pc;
    endtask

    // Hold reset for one edge, check the reset state, release just after the next edge.
    task automatic do_reset(input string tag, input logic rdy);
        @(negedge CLK);
        resetn    = 1'b0;
        mem_ready = rdy;
        @(posedge CLK);
        #1;
        chk({tag, " state"}, 32'(state_o), 32'd0);
        chk({tag, " pc"}, pc, 32'h0);
        chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, " halted"}, 32'(halted), 32'd0);
        chk({tag, " strobes"}, {29'd0, instr_we, regs_re, wb_en}, 32'd0);
        @(posedge CLK);
        #1;
        resetn    = 1'b1;
        mem_ready = 1'b0;
        model_pc  = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        int   hold_req;
        int   hold_halt;
        logic reached;
        tbl[0]  = mk(C_ALU,        1'b0, 32'h0,         32'h0,  0, 0, 32'h4,         1, 2'd0, 0, 0, 0, 4);
        tbl[1]  = mk(C_ALU,        1'b0, 32'h0,         32'h0,  3, 0, 32'h8,         1, 2'd0, 0, 0, 0, 6);
        tbl[2]  = mk(C_BR,         1'b1, 32'h100,       32'h0,  0, 0, 32'h100,       0, 2'd0, 0, 0, 0, 4);
        tbl[3]  = mk(C_JALR,       1'b0, 32'h203,       32'h0,  0, 0, 32'h200,       1, 2'd1, 0, 0, 0, 4);
        tbl[4]  = mk(C_LD,         1'b0, 32'h0,         32'h40, 0, 0, 32'h204,       1, 2'd2, 1, 0, 0, 6);
        tbl[5]  = mk(C_ST,         1'b0, 32'h0,         32'h80, 0, 2, 32'h208,       0, 2'd0, 1, 1, 0, 7);
        tbl[6]  = mk(C_JAL,        1'b0, 32'h10,        32'h0,  1, 0, 32'h10,        1, 2'd1, 0, 0, 0, 4);
        tbl[7]  = mk(C_BR,         1'b0, 32'h500,       32'h0,  0, 0, 32'h14,        0, 2'd0, 0, 0, 0, 4);
        tbl[8]  = mk(C_LD | C_ST,  1'b0, 32'h0,         32'h44, 2, 1, 32'h18,        1, 2'd2, 1, 0, 0, 7);
        tbl[9]  = mk(C_JAL | C_BR, 1'b1, 32'h31,        32'h0,  0, 0, 32'h30,        1, 2'd1, 0, 0, 0, 4);
        tbl[10] = mk(C_JAL,        1'b0, 32'hFFFF_FFFE, 32'h0,  0, 0, 32'hFFFF_FFFC, 1, 2'd1, 0, 0, 0, 4);
        tbl[11] = mk(C_ALU,        1'b0, 32'h0,         32'h0,  0, 0, 32'h0,         1, 2'd0, 0, 0, 0, 4);
        tbl[12] = mk(C_ST | C_JAL, 1'b0, 32'h900,       32'h8,  0, 0, 32'h4,         0, 2'd0, 1, 1, 0, 6);
        tbl[13] = mk(C_SYS | C_LD, 1'b0, 32'h0,         32'h0,  0, 0, 32'h4,         0, 2'd0, 0, 0, 1, 5);

        do_reset("reset", 1'b0);

        for (int i = 0; i < 14; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // HALT is sticky: no requests or exit for 20 cycles, even with mem_ready toggling.
        hold_req  = 0;
        hold_halt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            mem_ready = 1'($urandom % 2);
            #1;
            if (mem_req) hold_req++;
            if (halted && state_o == 3'd6) hold_halt++;
        end
        chk("halt no mem_req", hold_req, 0);
        chk("halt sticky", hold_halt, 20);
        do_reset("halt exit reset", 1'b0);

        // Reset while a load sits in MEM_WAIT with memory stalled.
        v = model(mk(C_ALU, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 2'd0, 0, 0, 0, 0), model_pc);
        run_vec(v, "pre-mw alu");
        {is_system, is_load, is_store, is_jal, is_jalr, is_branch} = C_LD;
        ls_addr = 32'h40;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            @(negedge CLK);
            mem_ready = (state_o == 3'd1);
            @(posedge CLK);
            #1;
            if (state_o == 3'd5) reached = 1'b1;
        end
        chk("mw reached MEM_WAIT", 32'(reached), 32'd1);
        @(negedge CLK);
        mem_ready = 1'b0;
        #1;
        chk("mw req held", 32'(mem_req), 32'd1);
        chk("mw addr held", mem_addr, 32'h40);
        do_reset("mw reset", 1'b1);

        // Randomized instruction stream.
        for (int n = 0; n < 150; n++) begin
            int r;
            r = int'($urandom % 100);
            if (r < 3) begin
                v.cls = C_SYS;
            end else begin
                case ($urandom % 7)
                    0: v.cls = C_ALU;
                    1: v.cls = C_LD;
                    2: v.cls = C_ST;
                    3: v.cls = C_JAL;
                    4: v.cls = C_JALR;
                    default: v.cls = C_BR;
                endcase
                if (r > 90) v.cls = v.cls | (6'b000001 << ($urandom % 5));
            end
            v.tk     = 1'($urandom % 2);
            v.target = $urandom;
            v.lsa    = $urandom;
            v.fd     = int'($urandom % 4);
            v.md     = int'($urandom % 4);
            v        = model(v, model_pc);
            run_vec(v, $sformatf("rnd%0d", n));
            if (v.exp_halt) do_reset($sformatf("rnd%0d reset", n), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
